adc_frame_align: RTL and testbench

- Per-ADC alignment controller that sits directly downstream of the one-line ADC deserializer and closes the loop back onto it.
- Watches the 6-bit deserialized ADC frame-clock line, scans the input delay taps to find the widest stable eye, and parks the delay at the eye centre.
- Then issues bitslips until the word equals the frame pattern.
- Outputs the DINC/DRST/BS controls for that line; the resulting tap and slip values are replicated to the data lines of the same ADC.

---
 rtl/adc_frame_align.sv | 237 +++++++++++++++++++++++
 tb/tb_adc_frame_align.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_align.sv
// rtl/adc_frame_align.sv - frame-line eye scan, centring and bitslip alignment controller
module adc_frame_align #(
    parameter logic [5:0] PATTERN    = 6'b111000,
    parameter int         MAX_TAP    = 63,
    parameter int         SETTLE_CYC = 16,
    parameter int         CHECK_CYC  = 64,
    parameter int         MIN_WIN    = 4,
    parameter int         MAX_SLIP   = 6
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [5:0] DIN,
    output logic       DINC,
    output logic       DRST,
    output logic       BS,
    output logic [7:0] TAP,
    output logic [7:0] WIN,
    output logic [2:0] SLIPS,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam logic [7:0] MAX_TAP_W   = 8'(MAX_TAP);
    localparam logic [6:0] SETTLE_LAST = 7'(SETTLE_CYC - 1);
    localparam logic [6:0] CHECK_LAST  = 7'(CHECK_CYC - 1);
    localparam logic [7:0] MIN_WIN_W   = 8'(MIN_WIN);
    localparam logic [2:0] MAX_SLIP_W  = 3'(MAX_SLIP);

    typedef enum logic [3:0] {
        S_IDLE, S_RSTD, S_SETTLE, S_CHECK, S_INC, S_EVAL,
        S_MOVE, S_MWAIT, S_SETTLE2, S_SLIPCHK, S_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tap_q, tap_d;
    logic [7:0] win_q, win_d;
    logic [2:0] slips_q, slips_d;
    logic       err_q, err_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] run_q, run_d;
    logic [7:0] best_q, best_d;
    logic [7:0] bstart_q, bstart_d;
    logic [7:0] target_q, target_d;
    logic [5:0] first_q, first_d;
    logic       dinc_q, dinc_d;
    logic       drst_q, drst_d;
    logic       bs_q, bs_d;
    logic [7:0] run_inc;
    logic       sample_ok;
    logic       tap_end;

    // A word is good if it is any cyclic rotation of the frame pattern
    function automatic logic good_word(input logic [5:0] w);
        logic [5:0] p;
        good_word = 1'b0;
        p = PATTERN;
        for (int i = 0; i < 6; i++) begin
            if (w == p) good_word = 1'b1;
            p = {p[4:0], p[5]};
        end
    endfunction

    // Next-state logic: scan, evaluate, centre, then slip
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        win_d     = win_q;
        slips_d   = slips_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        best_d    = best_q;
        bstart_d  = bstart_q;
        target_d  = target_q;
        first_d   = first_q;
        dinc_d    = 1'b0;
        drst_d    = 1'b0;
        bs_d      = 1'b0;
        tap_end   = 1'b0;
        run_inc   = run_q + 8'd1;
        sample_ok = good_word(DIN) && ((cnt_q == 7'd0) || (DIN == first_q));

        case (state_q)
            S_IDLE, S_FIN: begin
                if (START) begin
                    state_d = S_RSTD;
                    err_d   = 1'b0;
                end
            end
            S_RSTD: begin
                drst_d   = 1'b1;
                tap_d    = 8'd0;
                run_d    = 8'd0;
                best_d   = 8'd0;
                bstart_d = 8'd0;
                slips_d  = 3'd0;
                cnt_d    = 7'd0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_CHECK: begin
                if (cnt_q == 7'd0) first_d = DIN;
                if (!sample_ok) begin
                    run_d   = 8'd0;
                    tap_end = 1'b1;
                end else if (cnt_q == CHECK_LAST) begin
                    run_d   = run_inc;
                    tap_end = 1'b1;
                    // strict compare keeps the earliest of equal windows
                    if (run_inc > best_q) begin
                        best_d   = run_inc;
                        bstart_d = tap_q - run_inc + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
                if (tap_end) begin
                    cnt_d   = 7'd0;
                    state_d = (tap_q == MAX_TAP_W) ? S_EVAL : S_INC;
                end
            end
            S_INC: begin
                dinc_d  = 1'b1;
                tap_d   = tap_q + 8'd1;
                state_d = S_SETTLE;
            end
            S_EVAL: begin
                win_d = best_q;
                if (best_q < MIN_WIN_W) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    target_d = bstart_q + (best_q >> 1);
                    drst_d   = 1'b1;
                    tap_d    = 8'd0;
                    state_d  = S_MOVE;
                end
            end
            S_MOVE: begin
                cnt_d = 7'd0;
                if (tap_q == target_q) begin
                    state_d = S_SETTLE2;
                end else begin
                    dinc_d  = 1'b1;
                    tap_d   = tap_q + 8'd1;
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = S_MOVE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_SETTLE2: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = S_SLIPCHK;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_SLIPCHK: begin
                if (DIN == PATTERN) begin
                    err_d   = 1'b0;
                    state_d = S_FIN;
                end else if (slips_q == MAX_SLIP_W) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    bs_d    = 1'b1;
                    slips_d = slips_q + 3'd1;
                    cnt_d   = 7'd0;
                    state_d = S_SETTLE2;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            tap_q    <= 8'd0;
            win_q    <= 8'd0;
            slips_q  <= 3'd0;
            err_q    <= 1'b0;
            cnt_q    <= 7'd0;
            run_q    <= 8'd0;
            best_q   <= 8'd0;
            bstart_q <= 8'd0;
            target_q <= 8'd0;
            first_q  <= 6'd0;
            dinc_q   <= 1'b0;
            drst_q   <= 1'b0;
            bs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            win_q    <= win_d;
            slips_q  <= slips_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            best_q   <= best_d;
            bstart_q <= bstart_d;
            target_q <= target_d;
            first_q  <= first_d;
            dinc_q   <= dinc_d;
            drst_q   <= drst_d;
            bs_q     <= bs_d;
        end
    end

    assign DINC  = dinc_q;
    assign DRST  = drst_q;
    assign BS    = bs_q;
    assign TAP   = tap_q;
    assign WIN   = win_q;
    assign SLIPS = slips_q;
    assign ERR   = err_q;
    assign DONE  = (state_q == S_FIN);
    assign BUSY  = (state_q != S_IDLE) && (state_q != S_FIN);

endmodule

// File: tb/tb_adc_frame_align.sv
// tb/tb_adc_frame_align.sv - directed bench with delay-line and bitslip receiver model
module tb_adc_frame_align;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [5:0] DIN;
    logic       DINC, DRST, BS, BUSY, DONE, ERR;
    logic [7:0] TAP, WIN;
    logic [2:0] SLIPS;

    int total = 0;
    int fails = 0;

    int tap_m = 0;
    int dinc_cnt = 0, drst_cnt = 0, bs_cnt = 0, overlap_cnt = 0;
    int lo1 = 20, hi1 = 35, lo2 = 1000, hi2 = -1;
    int frz = 0;
    int bs_base = 0, dinc_base = 0, drst_base = 0;

    adc_frame_align dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DIN(DIN),
        .DINC(DINC), .DRST(DRST), .BS(BS), .TAP(TAP), .WIN(WIN),
        .SLIPS(SLIPS), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] rotr(input logic [5:0] w, input int r);
        logic [5:0] x;
        x = w;
        for (int i = 0; i < r; i++) x = {x[0], x[5:1]};
        return x;
    endfunction

    // Receiver model: delay tap follows DRST/DINC, word rotates right per BS
    always @(posedge CLK) begin
        if (DRST) tap_m <= 0;
        else if (DINC) tap_m <= tap_m + 1;
        dinc_cnt <= dinc_cnt + int'(DINC);
        drst_cnt <= drst_cnt + int'(DRST);
        bs_cnt   <= bs_cnt + int'(BS);
        if (int'(DINC) + int'(DRST) + int'(BS) > 1) overlap_cnt <= overlap_cnt + 1;
    end

    always_comb begin
        if ((tap_m >= lo1 && tap_m <= hi1) || (tap_m >= lo2 && tap_m <= hi2))
            DIN = rotr(6'b110001, (frz != 0) ? 0 : (bs_cnt - bs_base) % 6);
        else
            DIN = 6'b101010;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input int a, input int b, input int c, input int d, input int f);
        lo1 = a; hi1 = b; lo2 = c; hi2 = d; frz = f;
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        bs_base = bs_cnt; dinc_base = dinc_cnt; drst_base = drst_cnt;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!DONE && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done"}, int'(DONE), 1);
        chk({tag, "_busy"}, int'(BUSY), 0);
    endtask

    task automatic wait_tap(input int t);
        int n;
        n = 0;
        while (int'(TAP) != t && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_tap", int'(TAP), t);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge CLK);
        chk("reset_outputs", int'({DINC, DRST, BS, TAP, WIN, SLIPS, BUSY, DONE, ERR}), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // single window 20..35, one slip needed
        setup(20, 35, 1000, -1, 0);
        start_pulse();
        chk("t1_busy", int'(BUSY), 1);
        wait_done("t1");
        chk("t1_win", int'(WIN), 16);
        chk("t1_tap", int'(TAP), 28);
        chk("t1_slips", int'(SLIPS), 1);
        chk("t1_err", int'(ERR), 0);
        chk("t1_dinc", dinc_cnt - dinc_base, 63 + 28);
        chk("t1_drst", drst_cnt - drst_base, 2);
        chk("t1_bs", bs_cnt - bs_base, 1);

        // narrow window below minimum
        setup(10, 12, 1000, -1, 0);
        start_pulse();
        wait_done("t2");
        chk("t2_win", int'(WIN), 3);
        chk("t2_err", int'(ERR), 1);
        chk("t2_tap", int'(TAP), 63);
        chk("t2_bs", bs_cnt - bs_base, 0);
        chk("t2_dinc", dinc_cnt - dinc_base, 63);

        // two equal windows, earliest wins
        setup(5, 9, 40, 44, 0);
        start_pulse();
        wait_done("t3");
        chk("t3_win", int'(WIN), 5);
        chk("t3_tap", int'(TAP), 7);
        chk("t3_err", int'(ERR), 0);

        // window open at the last tap
        setup(60, 63, 1000, -1, 0);
        start_pulse();
        wait_done("t4");
        chk("t4_win", int'(WIN), 4);
        chk("t4_tap", int'(TAP), 62);
        chk("t4_err", int'(ERR), 0);
        chk("t4_dinc", dinc_cnt - dinc_base, 63 + 62);

        // slips never align the word
        setup(20, 35, 1000, -1, 1);
        start_pulse();
        wait_done("t5");
        chk("t5_bs", bs_cnt - bs_base, 6);
        chk("t5_slips", int'(SLIPS), 6);
        chk("t5_err", int'(ERR), 1);
        chk("t5_tap", int'(TAP), 28);

        // reset during scan, then restart
        setup(20, 35, 1000, -1, 0);
        start_pulse();
        wait_tap(30);
        RST_N = 1'b0;
        #1;
        chk("t6_reset_outputs", int'({DINC, DRST, BS, TAP, WIN, SLIPS, BUSY, DONE, ERR}), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        start_pulse();
        @(negedge CLK);
        chk("t6_drst_first", int'(DRST), 1);
        chk("t6_tap0", int'(TAP), 0);
        chk("t6_no_dinc_before_drst", dinc_cnt - dinc_base, 0);
        wait_done("t6");
        chk("t6_tap", int'(TAP), 28);
        chk("t6_win", int'(WIN), 16);

        // START while busy is ignored
        start_pulse();
        wait_tap(15);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done("t7");
        chk("t7_tap", int'(TAP), 28);
        chk("t7_win", int'(WIN), 16);
        chk("t7_drst", drst_cnt - drst_base, 2);
        chk("t7_dinc", dinc_cnt - dinc_base, 63 + 28);
        chk("t7_err", int'(ERR), 0);

        chk("pulse_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
